cci_mpf_pipe_stage_n: RTL and testbench

Parametrised multi-channel request stage for the MPF pipeline, placed between any two MPF shims on the request (Tx) path. Each of N_CHANNELS request channels gets a DEPTH-entry buffer with CCI-style almost-full backpressure toward the AFU side. Each channel also has a per-channel limit on active requests that is released by response-completion pulses from the FIU side. This generalises the fixed two-channel register/buffer stage in width, depth and channel count, and adds active-request throttling with error detection.

---
 rtl/cci_mpf_pipe_stage_pkg.sv | 33 +++
 rtl/cci_mpf_pipe_stage_chan.sv | 128 ++++++++++++
 rtl/cci_mpf_pipe_stage_n.sv | 57 +++++
 tb/tb_cci_mpf_pipe_stage_n.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_pipe_stage_pkg.sv
// cci_mpf_pipe_stage_pkg: shared sizing helpers and pointer type
// for the N-channel MPF request stage (stats: CCI_MPF_PIPE_STAGE_STATS_EN).
package cci_mpf_pipe_stage_pkg;

  localparam int STALL_CNT_W   = 32;
  localparam int PTR_IDX_MAX_W = 16;

  typedef struct packed {
    logic                     wrap;
    logic [PTR_IDX_MAX_W-1:0] idx;
  } ptr_t;

  function automatic int cnt_w_f(input int max_active);
    return $clog2(max_active + 1);
  endfunction

  function automatic int ptr_w_f(input int depth);
    return $clog2(depth);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p, input int depth);
    ptr_t n;
    n = p;
    if (p.idx == PTR_IDX_MAX_W'(depth - 1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx = p.idx + PTR_IDX_MAX_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/cci_mpf_pipe_stage_chan.sv
// cci_mpf_pipe_stage_chan: one request channel -- buffer, almost-full,
// issue register, active-request limit, sticky error, optional stall stats.
module cci_mpf_pipe_stage_chan
  import cci_mpf_pipe_stage_pkg::*;
#(
  parameter int DATA_WIDTH        = 600,
  parameter int DEPTH             = 8,
  parameter int ALMOST_FULL_SLACK = 4,
  parameter int MAX_ACTIVE_REQS   = 128,
  parameter int CNT_W             = cnt_w_f(MAX_ACTIVE_REQS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_almost_full,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_almost_full,
  input  logic                  rsp_done,
  output logic [CNT_W-1:0]      active_count,
  output logic                  error
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  localparam int PW = ptr_w_f(DEPTH);
  localparam int OW = PTR_IDX_MAX_W + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] AF_LVL =
    OW'(DEPTH - ALMOST_FULL_SLACK);
  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_ACTIVE_REQS);

  ptr_t wr_q, wr_d;
  ptr_t rd_q, rd_d;
  logic af_q, af_d;
  logic vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, wr_en, issue;
  logic [OW-1:0] occ, occ_next;

  always_comb begin
    full  = (wr_q.idx == rd_q.idx) &&
            (wr_q.wrap != rd_q.wrap);
    empty = (wr_q == rd_q);
    wr_en = in_valid && !full;
    issue = !empty && !out_almost_full &&
            (cnt_q < MAX_C);
    occ = {1'b0, wr_q.idx} - {1'b0, rd_q.idx} +
          ((wr_q.wrap != rd_q.wrap) ? DEPTH_C : '0);
    occ_next = occ + OW'(wr_en) - OW'(issue);

    wr_d  = wr_en ? ptr_inc(wr_q, DEPTH) : wr_q;
    rd_d  = issue ? ptr_inc(rd_q, DEPTH) : rd_q;
    af_d  = (occ_next >= AF_LVL);
    vld_d = issue;
    dat_d = issue ? mem_q[rd_q.idx[PW-1:0]] : dat_q;

    // Overflow is judged on the pre-cycle full flag.
    err_d = err_q | (in_valid & full);
    cnt_d = cnt_q;
    unique case (1'b1)
      issue && !rsp_done:
        cnt_d = cnt_q + CNT_W'(1);
      !issue && rsp_done && (cnt_q == '0):
        err_d = 1'b1;
      !issue && rsp_done && (cnt_q != '0):
        cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      af_q  <= 1'b1;
      vld_q <= 1'b0;
      dat_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      af_q  <= af_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q.idx[PW-1:0]] <= in_data;
  end

`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!empty && !issue && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign in_almost_full = af_q;
  assign out_valid      = vld_q;
  assign out_data       = dat_q;
  assign active_count   = cnt_q;
  assign error          = err_q;

endmodule

// File: rtl/cci_mpf_pipe_stage_n.sv
// cci_mpf_pipe_stage_n: N independent throttled request channels
// (stall counters with CCI_MPF_PIPE_STAGE_STATS_EN).
module cci_mpf_pipe_stage_n
  import cci_mpf_pipe_stage_pkg::*;
#(
  parameter int N_CHANNELS        = 2,
  parameter int DATA_WIDTH        = 600,
  parameter int DEPTH             = 8,
  parameter int ALMOST_FULL_SLACK = 4,
  parameter int MAX_ACTIVE_REQS   = 128,
  localparam int CNT_W = cnt_w_f(MAX_ACTIVE_REQS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_CHANNELS-1:0]            afu_tx_valid,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] afu_tx_data,
  output logic [N_CHANNELS-1:0]            afu_tx_almost_full,
  output logic [N_CHANNELS-1:0]            fiu_tx_valid,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] fiu_tx_data,
  input  logic [N_CHANNELS-1:0]            fiu_tx_almost_full,
  input  logic [N_CHANNELS-1:0]            fiu_rsp_done,
  output logic [N_CHANNELS*CNT_W-1:0]      active_count,
  output logic [N_CHANNELS-1:0]            error
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
  ,
  output logic [N_CHANNELS*STALL_CNT_W-1:0] stall_cycles
`endif
);

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
    cci_mpf_pipe_stage_chan #(
      .DATA_WIDTH        (DATA_WIDTH),
      .DEPTH             (DEPTH),
      .ALMOST_FULL_SLACK (ALMOST_FULL_SLACK),
      .MAX_ACTIVE_REQS   (MAX_ACTIVE_REQS),
      .CNT_W             (CNT_W)
    ) u_chan (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (afu_tx_valid[c]),
      .in_data         (afu_tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .in_almost_full  (afu_tx_almost_full[c]),
      .out_valid       (fiu_tx_valid[c]),
      .out_data        (fiu_tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .out_almost_full (fiu_tx_almost_full[c]),
      .rsp_done        (fiu_rsp_done[c]),
      .active_count    (active_count[c*CNT_W +: CNT_W]),
      .error           (error[c])
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
      ,
      .stall_cycles
        (stall_cycles[c*STALL_CNT_W +: STALL_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_cci_mpf_pipe_stage_n.sv
// tb_cci_mpf_pipe_stage_n: directed checks of latency, almost-full,
// overflow, throttling, channel independence and async reset.
module tb_cci_mpf_pipe_stage_n;
  localparam int NC    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SLACK = 4;
  localparam int MAXA  = 2;
  localparam int CW    = $clog2(MAXA + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NC-1:0]    afu_tx_valid = '0;
  logic [NC*DW-1:0] afu_tx_data = '0;
  logic [NC-1:0]    afu_tx_almost_full;
  logic [NC-1:0]    fiu_tx_valid;
  logic [NC*DW-1:0] fiu_tx_data;
  logic [NC-1:0]    fiu_tx_almost_full = '0;
  logic [NC-1:0]    fiu_rsp_done;
  logic [NC-1:0]    rsp_manual = '0;
  logic [NC-1:0]    loop_mask = '0;
  logic [NC*CW-1:0] active_count;
  logic [NC-1:0]    error;
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
  logic [NC*32-1:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Loopback completes every issued request the cycle it appears.
  assign fiu_rsp_done = rsp_manual | (fiu_tx_valid & loop_mask);

  cci_mpf_pipe_stage_n #(
    .N_CHANNELS        (NC),
    .DATA_WIDTH        (DW),
    .DEPTH             (DEPTH),
    .ALMOST_FULL_SLACK (SLACK),
    .MAX_ACTIVE_REQS   (MAXA)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .afu_tx_valid       (afu_tx_valid),
    .afu_tx_data        (afu_tx_data),
    .afu_tx_almost_full (afu_tx_almost_full),
    .fiu_tx_valid       (fiu_tx_valid),
    .fiu_tx_data        (fiu_tx_data),
    .fiu_tx_almost_full (fiu_tx_almost_full),
    .fiu_rsp_done       (fiu_rsp_done),
    .active_count       (active_count),
    .error              (error)
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  function automatic logic [DW-1:0] dat(input int c);
    return fiu_tx_data[c*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int c);
    return active_count[c*CW +: CW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    afu_tx_valid = '0;
    afu_tx_data = '0;
    fiu_tx_almost_full = '0;
    rsp_manual = '0;
    loop_mask = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    n_cmp++;
    if ({fiu_tx_valid, afu_tx_almost_full, error} !== 12'h0F0) begin
      n_bad++;
      $display("FAIL reset_flags: got v=%b af=%b e=%b want 0000/1111/0000",
               fiu_tx_valid, afu_tx_almost_full, error);
    end
    n_cmp++;
    if (fiu_tx_data !== '0 || active_count !== '0) begin
      n_bad++;
      $display("FAIL reset_data_cnt: got d=%h c=%h want 0/0",
               fiu_tx_data, active_count);
    end
    reset_n = 1'b1;
    cyc();
    n_cmp++;
    if (afu_tx_almost_full !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_af_drop: got %b want 0000",
               afu_tx_almost_full);
    end
  endtask

  task automatic test_latency();
    do_reset();
    repeat (2) cyc();
    afu_tx_valid[0] = 1'b1;
    afu_tx_data[31:0] = 32'hA5A5_0001;
    cyc();
    afu_tx_valid = '0;
    n_cmp++;
    if (fiu_tx_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL lat_t1: got %b want 0000", fiu_tx_valid);
    end
    cyc();
    n_cmp++;
    if (fiu_tx_valid !== 4'b0001 || dat(0) !== 32'hA5A5_0001) begin
      n_bad++;
      $display("FAIL lat_t2: got v=%b d=%h want 0001/a5a50001",
               fiu_tx_valid, dat(0));
    end
    n_cmp++;
    if (active_count !== 8'h01 || error !== 4'h0 ||
        afu_tx_almost_full !== 4'h0) begin
      n_bad++;
      $display("FAIL lat_side: got c=%h e=%b af=%b want 01/0000/0000",
               active_count, error, afu_tx_almost_full);
    end
    cyc();
    n_cmp++;
    if (fiu_tx_valid !== 4'b0000 || active_count !== 8'h01) begin
      n_bad++;
      $display("FAIL lat_pulse: got v=%b c=%h want 0000/01",
               fiu_tx_valid, active_count);
    end
  endtask

  task automatic test_almost_full();
    int got;
    do_reset();
    fiu_tx_almost_full = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      afu_tx_valid[0] = 1'b1;
      afu_tx_data[31:0] = 32'hB000_0000 + i;
      cyc();
      if (i == 2) begin
        n_cmp++;
        if (afu_tx_almost_full[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL af_after3: got %b want 0",
                   afu_tx_almost_full[0]);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (afu_tx_almost_full[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL af_after4: got %b want 1",
                   afu_tx_almost_full[0]);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (error[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL af_fill8_err: got %b want 0", error[0]);
        end
      end
    end
    afu_tx_valid = '0;
    n_cmp++;
    if (error !== 4'b0001 || fiu_tx_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL af_overflow: got e=%b v=%b want 0001/0",
               error, fiu_tx_valid[0]);
    end
    fiu_tx_almost_full = '0;
    loop_mask = 4'b0001;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (fiu_tx_valid[0]) begin
        n_cmp++;
        if (dat(0) !== 32'hB000_0000 + got) begin
          n_bad++;
          $display("FAIL af_drain_data: got %h want %h",
                   dat(0), 32'hB000_0000 + got);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 8 || afu_tx_almost_full[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL af_drain_count: got n=%0d af=%b want 8/0",
               got, afu_tx_almost_full[0]);
    end
    loop_mask = '0;
  endtask

  task automatic test_throttle();
    int got;
    do_reset();
    got = 0;
    for (int i = 0; i < 5; i++) begin
      afu_tx_valid[0] = 1'b1;
      afu_tx_data[31:0] = 32'hC000_0000 + i;
      cyc();
      if (fiu_tx_valid[0]) got++;
    end
    afu_tx_valid = '0;
    repeat (6) begin
      cyc();
      if (fiu_tx_valid[0]) got++;
    end
    n_cmp++;
    if (got != 2 || cnt(0) !== 2'd2) begin
      n_bad++;
      $display("FAIL thr_limit: got n=%0d c=%0d want 2/2",
               got, cnt(0));
    end
    rsp_manual[0] = 1'b1;
    cyc();
    rsp_manual = '0;
    n_cmp++;
    if (fiu_tx_valid[0] !== 1'b0 || cnt(0) !== 2'd1) begin
      n_bad++;
      $display("FAIL thr_rel_t1: got v=%b c=%0d want 0/1",
               fiu_tx_valid[0], cnt(0));
    end
    cyc();
    n_cmp++;
    if (fiu_tx_valid[0] !== 1'b1 || dat(0) !== 32'hC000_0002 ||
        cnt(0) !== 2'd2) begin
      n_bad++;
      $display("FAIL thr_rel_t2: got v=%b d=%h c=%0d want 1/c0000002/2",
               fiu_tx_valid[0], dat(0), cnt(0));
    end
    got = 0;
    repeat (6) begin
      cyc();
      if (fiu_tx_valid[0]) got++;
    end
    n_cmp++;
    if (got != 0) begin
      n_bad++;
      $display("FAIL thr_hold: got %0d issues want 0", got);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    afu_tx_valid[0] = 1'b1;
    afu_tx_data[31:0] = 32'hD000_0000;
    cyc();
    afu_tx_valid = '0;
    cyc();
    fiu_tx_almost_full[0] = 1'b1;
    afu_tx_valid[0] = 1'b1;
    afu_tx_data[31:0] = 32'hD000_0001;
    cyc();
    afu_tx_valid = '0;
    cyc();
    n_cmp++;
    if (cnt(0) !== 2'd1 || fiu_tx_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL same_pre: got c=%0d v=%b want 1/0",
               cnt(0), fiu_tx_valid[0]);
    end
    fiu_tx_almost_full = '0;
    rsp_manual[0] = 1'b1;
    cyc();
    n_cmp++;
    if (fiu_tx_valid[0] !== 1'b1 || dat(0) !== 32'hD000_0001 ||
        cnt(0) !== 2'd1 || error[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle: got v=%b d=%h c=%0d e=%b want 1/d0000001/1/0",
               fiu_tx_valid[0], dat(0), cnt(0), error[0]);
    end
    cyc();
    n_cmp++;
    if (cnt(0) !== 2'd0 || error[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL same_dec: got c=%0d e=%b want 0/0",
               cnt(0), error[0]);
    end
    cyc();
    rsp_manual = '0;
    n_cmp++;
    if (cnt(0) !== 2'd0 || error !== 4'b0001) begin
      n_bad++;
      $display("FAIL same_underflow: got c=%0d e=%b want 0/0001",
               cnt(0), error);
    end
  endtask

  task automatic test_independent();
    int got [NC];
    int first [NC];
    int last [NC];
    do_reset();
    for (int c = 0; c < NC; c++) begin
      got[c] = 0;
      first[c] = -1;
      last[c] = -1;
    end
    fiu_tx_almost_full = 4'b0100;
    loop_mask = 4'b1011;
    for (int k = 0; k < 12; k++) begin
      afu_tx_valid = (k < 6) ? 4'b1111 : 4'b0000;
      for (int c = 0; c < NC; c++)
        afu_tx_data[c*DW +: DW] = DW'(c * 256 + k);
      cyc();
      for (int c = 0; c < NC; c++) begin
        if (fiu_tx_valid[c]) begin
          n_cmp++;
          if (dat(c) !== DW'(c * 256 + got[c])) begin
            n_bad++;
            $display("FAIL ind_data ch%0d: got %h want %h",
                     c, dat(c), DW'(c * 256 + got[c]));
          end
          if (first[c] < 0) first[c] = k;
          last[c] = k;
          got[c]++;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (c != 2) begin
        n_cmp++;
        if (got[c] != 6 || first[c] != 1 || last[c] != 6) begin
          n_bad++;
          $display("FAIL ind_rate ch%0d: got n=%0d %0d..%0d want 6 1..6",
                   c, got[c], first[c], last[c]);
        end
      end
    end
    n_cmp++;
    if (got[2] != 0 || afu_tx_almost_full[2] !== 1'b1 ||
        error !== 4'b0000) begin
      n_bad++;
      $display("FAIL ind_stalled: got n=%0d af=%b e=%b want 0/1/0000",
               got[2], afu_tx_almost_full[2], error);
    end
`ifdef CCI_MPF_PIPE_STAGE_STATS_EN
    n_cmp++;
    if (stall_cycles[2*32 +: 32] !== 32'd11 ||
        stall_cycles[0 +: 32] !== 32'd0) begin
      n_bad++;
      $display("FAIL ind_stall_cnt: got ch2=%0d ch0=%0d want 11/0",
               stall_cycles[2*32 +: 32], stall_cycles[0 +: 32]);
    end
`endif
    fiu_tx_almost_full = '0;
    loop_mask = 4'b1111;
    got[2] = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (fiu_tx_valid[2]) begin
        n_cmp++;
        if (dat(2) !== DW'(512 + got[2])) begin
          n_bad++;
          $display("FAIL ind_drain ch2: got %h want %h",
                   dat(2), DW'(512 + got[2]));
        end
        got[2]++;
      end
    end
    n_cmp++;
    if (got[2] != 6) begin
      n_bad++;
      $display("FAIL ind_drain_count: got %0d want 6", got[2]);
    end
    loop_mask = '0;
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    fiu_tx_almost_full = 4'b0001;
    afu_tx_valid = 4'b0011;
    afu_tx_data[31:0] = 32'hE000_0000;
    afu_tx_data[63:32] = 32'hE100_0000;
    cyc();
    afu_tx_data[31:0] = 32'hE000_0001;
    afu_tx_data[63:32] = 32'hE100_0001;
    cyc();
    afu_tx_valid = 4'b0001;
    afu_tx_data[31:0] = 32'hE000_0002;
    cyc();
    afu_tx_valid = '0;
    n_cmp++;
    if (fiu_tx_valid !== 4'b0010 || cnt(1) !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_pre: got v=%b c1=%0d want 0010/2",
               fiu_tx_valid, cnt(1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (fiu_tx_valid !== '0 || fiu_tx_data !== '0 ||
        afu_tx_almost_full !== 4'hF || active_count !== '0 ||
        error !== '0) begin
      n_bad++;
      $display("FAIL mid_async: got v=%b af=%b c=%h e=%b want 0/f/0/0",
               fiu_tx_valid, afu_tx_almost_full, active_count, error);
    end
    cyc();
    reset_n = 1'b1;
    fiu_tx_almost_full = '0;
    got = 0;
    repeat (10) begin
      cyc();
      if (fiu_tx_valid[0]) got++;
    end
    n_cmp++;
    if (got != 0) begin
      n_bad++;
      $display("FAIL mid_discard: got %0d issues want 0", got);
    end
    rsp_manual[1] = 1'b1;
    cyc();
    rsp_manual = '0;
    n_cmp++;
    if (error !== 4'b0010 || cnt(1) !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_late_rsp: got e=%b c1=%0d want 0010/0",
               error, cnt(1));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_almost_full();
    test_throttle();
    test_same_cycle();
    test_independent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
